// File: rtl/mult_chk_pkg.sv
// mult_chk_pkg
// Shared types and width helpers for the approximate-multiplier sweep checker.
//   chk_state_t       : sweep FSM states
//   DEF_W / DEF_LAT   : default operand width and launch-to-sample latency
//   prod_w/cnt_w/sum_w: product, error-count and error-sum widths for a given W
package mult_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } chk_state_t;

  localparam int DEF_W   = 8;
  localparam int DEF_LAT = 3;

  // PROD_W = 2W
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // CNT_W = 2W+1: holds a count of all 2^(2W) pairs
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  // SUM_W = 4W: 2^(2W) pairs times an error below 2^(2W)
  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/op_delay.sv
// op_delay
// LAT-stage shift register carrying {valid, a, b} for each launched operand
// pair, so the checker knows which pair a returning product belongs to.
//   i_clk, i_reset : clock, synchronous active-high flush
//   i_vld/i_a/i_b  : pair launched at this edge
//   o_vld/o_a/o_b  : pair whose product is sampled at the next edge
module op_delay #(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_vld,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_vld,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);

  logic [LAT-1:0]        r_vld_pipe;
  logic [LAT-1:0][W-1:0] r_a_pipe;
  logic [LAT-1:0][W-1:0] r_b_pipe;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_a_pipe   <= '0;
      r_b_pipe   <= '0;
    end else begin
      r_vld_pipe[0] <= i_vld;
      r_a_pipe[0]   <= i_a;
      r_b_pipe[0]   <= i_b;
      for (int i = 1; i < LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_a_pipe[i]   <= r_a_pipe[i-1];
        r_b_pipe[i]   <= r_b_pipe[i-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[LAT-1];
  assign o_a   = r_a_pipe[LAT-1];
  assign o_b   = r_b_pipe[LAT-1];

endmodule

// File: rtl/mult_sweep_checker.sv
// mult_sweep_checker
// Self-test engine: sweeps every W-bit operand pair (a outer, b inner) into a
// multiplier under test, compares each returned product with the exact product
// and accumulates error-distance statistics.
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_start           : request a sweep (honoured in IDLE or DONE only)
//   o_busy, o_done    : sweep in progress / sweep finished (level)
//   o_op_a, o_op_b    : registered operands to the multiplier
//   i_prod_in         : product returned LAT edges after launch
//   o_err_count       : pairs with nonzero error distance
//   o_ed_sum          : sum of error distances
//   o_ed_max          : largest error distance
//   o_worst_a/b       : first pair that reached o_ed_max
module mult_sweep_checker
  import mult_chk_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int LAT = DEF_LAT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [W-1:0]          o_op_a,
  output logic [W-1:0]          o_op_b,
  input  logic [prod_w(W)-1:0]  i_prod_in,
  output logic [cnt_w(W)-1:0]   o_err_count,
  output logic [sum_w(W)-1:0]   o_ed_sum,
  output logic [prod_w(W)-1:0]  o_ed_max,
  output logic [W-1:0]          o_worst_a,
  output logic [W-1:0]          o_worst_b
);

  localparam int PW = prod_w(W);
  localparam int CW = cnt_w(W);
  localparam int SW = sum_w(W);

  chk_state_t     r_state;
  logic [PW-1:0]  r_k;
  logic           r_busy, r_done;
  logic [W-1:0]   r_op_a, r_op_b;
  logic [CW-1:0]  r_err_count;
  logic [SW-1:0]  r_ed_sum;
  logic [PW-1:0]  r_ed_max;
  logic [W-1:0]   r_worst_a, r_worst_b;

  logic           w_accept, w_launch, w_last;
  logic [W-1:0]   w_launch_a, w_launch_b;
  logic           w_dly_vld;
  logic [W-1:0]   w_dly_a, w_dly_b;
  logic [PW-1:0]  w_exact, w_ed;

  assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_launch = w_accept || (r_state == ST_SWEEP);

  // Pair 0 launches on the accepting edge itself; r_k already points at pair 1.
  assign w_launch_a = w_accept ? '0 : r_k[PW-1:W];
  assign w_launch_b = w_accept ? '0 : r_k[W-1:0];

  op_delay #(.W(W), .LAT(LAT)) u_op_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (w_launch),
    .i_a     (w_launch_a),
    .i_b     (w_launch_b),
    .o_vld   (w_dly_vld),
    .o_a     (w_dly_a),
    .o_b     (w_dly_b)
  );

  assign w_exact = PW'(w_dly_a) * PW'(w_dly_b);
  assign w_ed    = (i_prod_in >= w_exact) ? (i_prod_in - w_exact) : (w_exact - i_prod_in);
  // The all-ones pair is always the last one launched.
  assign w_last  = w_dly_vld && (&w_dly_a) && (&w_dly_b);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
      r_worst_a   <= '0;
      r_worst_b   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_k     <= PW'(1);
          end
        end
        ST_SWEEP: begin
          r_k <= r_k + PW'(1);
          if (&r_k) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Operands hold once launching stops (DRAIN/DONE).
      if (w_launch) begin
        r_op_a <= w_launch_a;
        r_op_b <= w_launch_b;
      end

      // The delay line is empty whenever a start is accepted, so clearing
      // never races with a sample.
      if (w_accept) begin
        r_err_count <= '0;
        r_ed_sum    <= '0;
        r_ed_max    <= '0;
        r_worst_a   <= '0;
        r_worst_b   <= '0;
      end else if (w_dly_vld) begin
        r_ed_sum <= r_ed_sum + SW'(w_ed);
        if (w_ed != '0) r_err_count <= r_err_count + CW'(1);
        // Strict compare keeps the first pair on ties.
        if (w_ed > r_ed_max) begin
          r_ed_max  <= w_ed;
          r_worst_a <= w_dly_a;
          r_worst_b <= w_dly_b;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_err_count = r_err_count;
  assign o_ed_sum    = r_ed_sum;
  assign o_ed_max    = r_ed_max;
  assign o_worst_a   = r_worst_a;
  assign o_worst_b   = r_worst_b;

endmodule

// File: doc/mult_sweep_checker.md
# mult_sweep_checker

- Hardware self-test engine for an 8-bit approximate multiplier wrapper.
- Drives every operand pair into the multiplier under test and reads back each product.
- Compares each product against the exact product and accumulates error-distance statistics on chip.
- Sits beside the multiplier wrapper, which receives registered operands and returns a registered product. It lets silicon or FPGA builds report error metrics without a simulation bench; MRED-style ratios are computed offline from the counters.

## Interface

- W, default 8: operand width; the product is 2W bits.
- LAT, default 3, minimum 1: clock edges from the edge that launches an operand pair to the edge that samples its product. 3 matches a wrapper with input and output registers.

Ports (clock and reset first):

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a sweep; sampled only in IDLE or DONE.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  level; high in DONE until the next accepted start or reset.
- op_a  out  W  registered operand A to the multiplier.
- op_b  out  W  registered operand B to the multiplier.
- prod_in  in  2W  product returned by the multiplier.
- err_count  out  2W+1  number of pairs with nonzero error distance.
- ed_sum  out  4W  sum of |prod_in − a·b| over all pairs.
- ed_max  out  2W  largest single error distance.
- worst_a  out  W  operand A of the first pair reaching ed_max.
- worst_b  out  W  operand B of the first pair reaching ed_max.

## Operation

- **States:** IDLE, SWEEP, DRAIN, DONE.
- **IDLE:** on `start`, clear all statistics and the pair counter `k` (2W bits), then enter SWEEP.
- **SWEEP:** `op_a = k[2W−1:W]` and `op_b = k[W−1:0]`, so B increments fastest (a outer, b inner). `k` increments once per cycle. After the launch with k = 2^(2W)−1, enter DRAIN.
- **DRAIN:** operands hold their last value. Leave DRAIN when the last pair has been sampled.
- **DONE:** statistics hold. `start` clears the statistics and re-enters SWEEP exactly as from IDLE.
- **start while busy:** ignored.
- **Operand delay:** a LAT-deep valid/operand delay line tracks each launched pair. At each edge where the delayed valid bit is set:
  - compute exact = a_d·b_d (2W bits, unsigned);
  - compute ED = |prod_in − exact| (unsigned, 2W bits, no wrap);
  - add ED to `ed_sum`;
  - if ED ≠ 0, increment `err_count`;
  - if ED > `ed_max` (strict), update `ed_max`, `worst_a` and `worst_b`. On a tie the first pair is kept.
- **Zero operands:** exact = 0. Any nonzero `prod_in` counts as an error; there is no divide and no special case.
- **Counter widths** are sized so they never overflow: `err_count` ≤ 2^(2W) and `ed_sum` < 2^(4W).
- **reset**, at any time including mid-sweep: state goes to IDLE and the delay line is flushed. In-flight products are discarded.

## Timing

- **Reset values:** busy, done, op_a, op_b, err_count, ed_sum, ed_max, worst_a, worst_b are all 0.
- **Edge E0** is the edge that samples `start`. From E0: busy = 1 and op_a/op_b = 0/0.
- **Launch and sample:** pair k is launched at edge E0+k, and its product is sampled at edge E0+k+LAT.
- **Final sample** is at edge E0+2^(2W)−1+LAT. At that edge:
  - the statistics reach their final values;
  - the state goes to DONE;
  - busy = 0 and done = 1 are visible from that edge.
- **Sweep duration:** busy is high for exactly 2^(2W)−1+LAT cycles (65538 at default parameters).
- **Restart:** `start` in DONE clears the statistics at the accepting edge. done drops at the same edge that busy rises.

## Structure

- **Package `mult_chk_pkg`:**
  - state enum `chk_state_t` (IDLE, SWEEP, DRAIN, DONE);
  - default W and LAT localparams;
  - width helpers PROD_W = 2W, CNT_W = 2W+1, SUM_W = 4W.
- **Sub-module `op_delay`:** parameterised LAT-stage shift register carrying {valid, a, b}, with synchronous flush on reset.
- **Top level:** FSM, pair counter, and the ED/statistics datapath.

## Test plan

- **Exact multiplier model** (prod = a·b, LAT 3), start pulse:
  - busy high for 65538 cycles, then done = 1;
  - err_count = 0, ed_sum = 0, ed_max = 0, worst = (0,0).
- **Model returning 0 always:**
  - err_count = 65025;
  - ed_sum = 1,065,369,600;
  - ed_max = 65025;
  - worst = (255,255).
- **Model returning a·b | 1:**
  - err_count = 49152, ed_sum = 49152, ed_max = 1;
  - worst = (0,0), which checks the first-occurrence tie rule.
- **Reset mid-sweep** (reset at k = 1000):
  - next cycle: busy = 0, done = 0, all statistics 0, op_a/op_b = 0;
  - a subsequent start gives results identical to a clean sweep.
- **Start pulsed during SWEEP** at k = 500:
  - ignored: k continues and the final results are unchanged.
  - A second start in DONE clears the statistics at the accepting edge and reproduces the same final values.
